mul_datapath: RTL and testbench
===============================

// Module: mul_datapath
// PURPOSE
//  Datapath for the repeated-addition multiplier; consumes ldA/ldB/ldP/clrP/decB from the
//  multiplier controller FSM and returns eqz to it. Holds multiplicand A, down-counter B and
//  accumulator P; computes P = A*B by adding A to P once per decrement of B.
//  Operands arrive one at a time on a shared data_in bus: A first, then B.
// PARAMETERS
//  WIDTH   16        operand width (A, B, data_in)
//  PWIDTH  2*WIDTH   accumulator/product width; must be >= WIDTH (elaboration error otherwise)
// PORTS
//  clk      in   1       single clock, rising edge
//  rst      in   1       asynchronous reset, active-high
//  data_in  in   WIDTH   shared operand bus, sampled on ldA / ldB
//  ldA      in   1       load A from data_in
//  ldB      in   1       load B from data_in
//  ldP      in   1       accumulate P <= P + A (gated, see below)
//  clrP     in   1       clear P and ovf
//  decB     in   1       decrement B (gated, see below)
//  eqz      out  1       B == 0; combinational from B register
//  product  out  PWIDTH  current P register value
//  ovf      out  1       sticky: an accumulation carried out of PWIDTH bits
// BEHAVIOUR
//  - rst=1 (async, any time, incl. mid-multiply):
//      A=0, B=0, P=0, ovf=0 -> product=0, ovf=0, eqz=1 immediately; no edge needed.
//  - A register: ldA -> A <= data_in next edge; else hold.
//  - B register, priority ldB > decB:
//      ldB -> B <= data_in.
//      decB & B!=0 -> B <= B-1.
//      decB & B==0 -> hold at 0; no wrap to all-ones.
//  - P/ovf, priority clrP > ldP:
//      clrP -> P <= 0, ovf <= 0.
//      ldP & B!=0 -> P <= (P + zero-extended A) mod 2^PWIDTH; ovf <= ovf | carry-out.
//      ldP & B==0 -> P, ovf hold.
//      Gating guarantees exact A*B even if the controller asserts ldP/decB for extra
//      cycles while waiting on eqz.
//  - Same-edge interactions (all use pre-edge register values):
//      ldA & ldP -> P adds old A.
//      ldB & ldP -> gate uses old B.
//      ldP & decB -> one add and one decrement per cycle.
//  - Latency: eqz/product reflect register state 1 cycle after the controlling edge.
//      A full multiply takes B_init accumulate cycles after load/clear.
//      B=0 gives eqz=1 right after ldB; P stays 0.
//  - Width: with PWIDTH >= 2*WIDTH ovf can never set; ovf only meaningful for narrower PWIDTH.
//  - No internal FSM; all sequencing owned by the controller. Outputs never X after reset.
// TESTING
//  1. Reset: assert rst between edges -> product=0, ovf=0, eqz=1 without a clock edge.
//  2. Normal: ldA data_in=7; ldB data_in=5 + clrP; ldP+decB held 7 cycles
//       -> product=35 after 5th add, eqz=1, product remains 35 for extra cycles.
//  3. Zero: A=9, B=0, clrP, ldP+decB x3 -> eqz=1 throughout, product=0, B stays 0 (no wrap).
//  4. Overflow (WIDTH=4, PWIDTH=4): A=15, B=3 -> product=13 (45 mod 16), ovf=1;
//       then clrP -> product=0, ovf=0.
//  5. Priority: B=4, ldB(data_in=9)+decB -> B=9;
//       P=20, clrP+ldP -> P=0; ldA(data_in=2)+ldP with A=3 -> P increases by 3.
//  6. Reset mid-op: A=6, B=10, after 4 adds (P=24) pulse rst -> all zero, eqz=1;
//       reload A=6, B=2 -> product=12.

Source files
------------

// File: rtl/mul_datapath_if.sv
// Controller <-> datapath bundle for the repeated-addition multiplier.
// master: controller side (drives operand bus and control strobes, reads status).
// slave : datapath side (samples operand bus and strobes, returns eqz/product/ovf).
interface mul_datapath_if #(
   parameter int WIDTH  = 16,
   parameter int PWIDTH = 2 * WIDTH
);
   logic [WIDTH-1:0]  data_in;   // shared operand bus, A then B
   logic              ldA;       // load A from data_in
   logic              ldB;       // load B from data_in
   logic              ldP;       // accumulate P += A (gated by B != 0)
   logic              clrP;      // clear P and ovf
   logic              decB;      // decrement B (gated by B != 0)
   logic              eqz;       // B == 0
   logic [PWIDTH-1:0] product;   // current accumulator
   logic              ovf;       // sticky accumulation carry-out

   modport master (
      output data_in, ldA, ldB, ldP, clrP, decB,
      input  eqz, product, ovf
   );

   modport slave (
      input  data_in, ldA, ldB, ldP, clrP, decB,
      output eqz, product, ovf
   );
endinterface

// File: rtl/mul_datapath.sv
// Purpose: multiplier datapath -- A register, B down-counter, P accumulator with sticky ovf.
// Latency: registers update on the controlling edge; eqz/product/ovf reflect them 1 cycle later.
// Backpressure: none; controller sequences strobes and watches eqz. Ports: clk, rst, dp (slave).
module mul_datapath #(
   parameter int WIDTH  = 16,
   parameter int PWIDTH = 2 * WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   mul_datapath_if.slave  dp
);

   generate
      if (PWIDTH < WIDTH) begin : g_bad_width
         $error("mul_datapath: PWIDTH must be >= WIDTH");
      end
   endgenerate

   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [PWIDTH-1:0] p_q, p_d;
   logic              ovf_q, ovf_d;
   logic              b_nz;
   logic [PWIDTH:0]   sum;

   // Both ldP and decB are gated on the pre-edge B so a controller that keeps
   // strobing while it waits for eqz cannot over-accumulate or wrap B.
   assign b_nz = |b_q;
   assign sum  = {1'b0, p_q} + (PWIDTH+1)'(a_q);

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      p_d   = p_q;
      ovf_d = ovf_q;

      if (dp.ldA) begin
         a_d = dp.data_in;
      end

      if (dp.ldB) begin
         b_d = dp.data_in;
      end else if (dp.decB && b_nz) begin
         b_d = b_q - WIDTH'(1);
      end

      if (dp.clrP) begin
         p_d   = '0;
         ovf_d = 1'b0;
      end else if (dp.ldP && b_nz) begin
         p_d   = sum[PWIDTH-1:0];
         ovf_d = ovf_q | sum[PWIDTH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         p_q   <= '0;
         ovf_q <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         p_q   <= p_d;
         ovf_q <= ovf_d;
      end
   end

   assign dp.eqz     = ~b_nz;
   assign dp.product = p_q;
   assign dp.ovf     = ovf_q;

endmodule

// File: tb/tb_mul_datapath.sv
// Bench for mul_datapath: a wide instance (16/32) and a narrow instance (4/4) for overflow.
// A behavioural model predicts each cycle's outputs into a queue; the sample after the
// edge pops and compares. Scenario tasks add fixed expected values on top.
module tb_mul_datapath;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mul_datapath_if #(.WIDTH(16), .PWIDTH(32)) if0 ();
   mul_datapath_if #(.WIDTH(4),  .PWIDTH(4))  if1 ();

   mul_datapath #(.WIDTH(16), .PWIDTH(32)) u_wide   (.clk(clk), .rst(rst), .dp(if0.slave));
   mul_datapath #(.WIDTH(4),  .PWIDTH(4))  u_narrow (.clk(clk), .rst(rst), .dp(if1.slave));

   typedef struct {
      int          sel;
      logic [31:0] p;
      logic        o;
      logic        z;
   } exp_t;

   exp_t   exp_q[$];
   int     total = 0;
   int     bad   = 0;

   // model state per instance: index 0 = wide, 1 = narrow
   longint m_a[2], m_b[2], m_p[2];
   bit     m_o[2];
   int     pw_bits[2] = '{32, 4};
   longint w_mask[2]  = '{64'hFFFF, 64'hF};
   longint p_mask[2]  = '{64'hFFFF_FFFF, 64'hF};

   function automatic logic [31:0] act_p(input int s);
      return (s == 0) ? if0.product : {28'b0, if1.product};
   endfunction

   function automatic logic act_o(input int s);
      return (s == 0) ? if0.ovf : if1.ovf;
   endfunction

   function automatic logic act_z(input int s);
      return (s == 0) ? if0.eqz : if1.eqz;
   endfunction

   // One clock cycle on instance s with the given strobes; model predicts, DUT is checked.
   task automatic cyc(input int s, input logic [15:0] din,
                      input logic la, input logic lb, input logic lp,
                      input logic cp, input logic db);
      longint na, nb, np, t;
      bit     no;
      exp_t   e, g;
      if (s == 0) begin
         if0.data_in = din; if0.ldA = la; if0.ldB = lb; if0.ldP = lp; if0.clrP = cp; if0.decB = db;
      end else begin
         if1.data_in = din[3:0]; if1.ldA = la; if1.ldB = lb; if1.ldP = lp; if1.clrP = cp; if1.decB = db;
      end
      na = m_a[s]; nb = m_b[s]; np = m_p[s]; no = m_o[s];
      if (la) na = longint'(din) & w_mask[s];
      if (lb) nb = longint'(din) & w_mask[s];
      else if (db && m_b[s] != 0) nb = m_b[s] - 1;
      if (cp) begin
         np = 0; no = 1'b0;
      end else if (lp && m_b[s] != 0) begin
         t  = m_p[s] + m_a[s];
         np = t & p_mask[s];
         no = m_o[s] | ((t >> pw_bits[s]) != 0);
      end
      e.sel = s; e.p = np[31:0]; e.o = no; e.z = (nb == 0);
      exp_q.push_back(e);
      @(posedge clk);
      m_a[s] = na; m_b[s] = nb; m_p[s] = np; m_o[s] = no;
      #1;
      if (s == 0) begin
         if0.ldA = 0; if0.ldB = 0; if0.ldP = 0; if0.clrP = 0; if0.decB = 0;
      end else begin
         if1.ldA = 0; if1.ldB = 0; if1.ldP = 0; if1.clrP = 0; if1.decB = 0;
      end
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL scoreboard_empty inst=%0d actual=none required=entry", s);
      end else begin
         g = exp_q.pop_front();
         if (act_p(g.sel) !== g.p || act_o(g.sel) !== g.o || act_z(g.sel) !== g.z) begin
            bad++;
            $display("FAIL cycle_check inst=%0d actual p=%0d o=%b z=%b required p=%0d o=%b z=%b",
                     g.sel, act_p(g.sel), act_o(g.sel), act_z(g.sel), g.p, g.o, g.z);
         end
      end
   endtask

   // Async reset pulse placed between clock edges; outputs checked before any edge.
   task automatic pulse_reset();
      #2;
      rst = 1'b1;
      #1;
      for (int s = 0; s < 2; s++) begin
         total++;
         if (act_p(s) !== 32'd0 || act_o(s) !== 1'b0 || act_z(s) !== 1'b1) begin
            bad++;
            $display("FAIL reset_state inst=%0d actual p=%0d o=%b z=%b required p=0 o=0 z=1",
                     s, act_p(s), act_o(s), act_z(s));
         end
         m_a[s] = 0; m_b[s] = 0; m_p[s] = 0; m_o[s] = 1'b0;
      end
      #1;
      rst = 1'b0;
   endtask

   task automatic check_p(input string name, input int s, input logic [31:0] req);
      total++;
      if (act_p(s) !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act_p(s), req);
      end
   endtask

   task automatic test_reset();
      pulse_reset();
   endtask

   task automatic test_normal();
      cyc(0, 16'd7, 1, 0, 0, 0, 0);
      cyc(0, 16'd5, 0, 1, 0, 1, 0);
      for (int i = 0; i < 7; i++) begin
         cyc(0, 16'd0, 0, 0, 1, 0, 1);
         if (i == 4) check_p("normal_after_5_adds", 0, 32'd35);
      end
      check_p("normal_hold_35", 0, 32'd35);
      total++;
      if (if0.eqz !== 1'b1) begin
         bad++;
         $display("FAIL normal_eqz actual=%b required=1", if0.eqz);
      end
   endtask

   task automatic test_zero();
      cyc(0, 16'd9, 1, 0, 0, 0, 0);
      cyc(0, 16'd0, 0, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 16'd0, 0, 0, 1, 0, 1);
         total++;
         if (if0.eqz !== 1'b1) begin
            bad++;
            $display("FAIL zero_eqz actual=%b required=1", if0.eqz);
         end
      end
      check_p("zero_product", 0, 32'd0);
   endtask

   task automatic test_overflow();
      cyc(1, 16'd15, 1, 0, 0, 0, 0);
      cyc(1, 16'd3, 0, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++) cyc(1, 16'd0, 0, 0, 1, 0, 1);
      check_p("ovf_product", 1, 32'd13);
      total++;
      if (if1.ovf !== 1'b1) begin
         bad++;
         $display("FAIL ovf_set actual=%b required=1", if1.ovf);
      end
      cyc(1, 16'd0, 0, 0, 0, 1, 0);
      check_p("ovf_clr_product", 1, 32'd0);
      total++;
      if (if1.ovf !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clr actual=%b required=0", if1.ovf);
      end
   endtask

   task automatic test_priority();
      // ldB beats decB: B becomes 9, seen as 9 adds of A=1
      cyc(0, 16'd4, 0, 1, 0, 0, 0);
      cyc(0, 16'd9, 0, 1, 0, 0, 1);
      cyc(0, 16'd1, 1, 0, 0, 1, 0);
      for (int i = 0; i < 12; i++) cyc(0, 16'd0, 0, 0, 1, 0, 1);
      check_p("prio_ldb_over_decb", 0, 32'd9);
      // clrP beats ldP
      cyc(0, 16'd5, 1, 0, 0, 0, 0);
      cyc(0, 16'd10, 0, 1, 0, 1, 0);
      for (int i = 0; i < 4; i++) cyc(0, 16'd0, 0, 0, 1, 0, 1);
      check_p("prio_p20", 0, 32'd20);
      cyc(0, 16'd0, 0, 0, 1, 1, 0);
      check_p("prio_clr_over_ldp", 0, 32'd0);
      // ldA with ldP adds the old A
      cyc(0, 16'd3, 1, 0, 0, 0, 0);
      cyc(0, 16'd2, 1, 0, 1, 0, 0);
      check_p("prio_old_a", 0, 32'd3);
      cyc(0, 16'd0, 0, 0, 1, 0, 0);
      check_p("prio_new_a", 0, 32'd5);
   endtask

   task automatic test_reset_mid_op();
      cyc(0, 16'd6, 1, 0, 0, 0, 0);
      cyc(0, 16'd10, 0, 1, 0, 1, 0);
      for (int i = 0; i < 4; i++) cyc(0, 16'd0, 0, 0, 1, 0, 1);
      check_p("midop_p24", 0, 32'd24);
      pulse_reset();
      cyc(0, 16'd6, 1, 0, 0, 0, 0);
      cyc(0, 16'd2, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 16'd0, 0, 0, 1, 0, 1);
      check_p("midop_reload_12", 0, 32'd12);
   endtask

   task automatic test_back_to_back();
      // random operand pairs, one multiply straight after another
      for (int k = 0; k < 6; k++) begin
         logic [15:0] a, b;
         a = 16'($urandom_range(0, 65535));
         b = 16'($urandom_range(0, 12));
         cyc(0, a, 1, 0, 0, 0, 0);
         cyc(0, b, 0, 1, 0, 1, 0);
         for (int i = 0; i < 13; i++) cyc(0, 16'd0, 0, 0, 1, 0, 1);
         check_p("b2b_product", 0, 32'(a) * 32'(b));
      end
   endtask

   initial begin
      if0.data_in = '0; if0.ldA = 0; if0.ldB = 0; if0.ldP = 0; if0.clrP = 0; if0.decB = 0;
      if1.data_in = '0; if1.ldA = 0; if1.ldB = 0; if1.ldP = 0; if1.clrP = 0; if1.decB = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_normal();
      test_zero();
      test_overflow();
      test_priority();
      test_reset_mid_op();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
